ifft8_serial: RTL



---
 rtl/ifft_pkg.sv | 68 ++++++
 rtl/ifft_butterfly.sv | 71 +++++++
 rtl/ifft8_serial.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ifft_pkg.sv
// ifft_pkg: shared constants, types and helpers for the serial 8-point IFFT.
//   - component widths of the input bins, the register file and the outputs
//   - the 1/sqrt(2) twiddle constant (91 / 2^7)
//   - the control FSM state encoding
//   - bitrev3: input bins are stored bit-reversed so the outputs come out in natural order
//   - bf_addr: maps a compute step (stage*4 + butterfly) to its top/bot addresses and twiddle index
//   - sat_out: divides by 8 and saturates a register-file word to the output width
package ifft_pkg;

  localparam int IN_W     = 12;
  localparam int ACC_W    = 16;
  localparam int OUT_W    = 12;
  localparam int TW_FRAC  = 7;
  localparam int NORM_SH  = 3;   // the 1/8 of the inverse transform
  localparam int LAST_STEP = 11; // 3 stages x 4 butterflies, counted from 0

  localparam logic signed [8:0] TW_C = 9'sd91;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] top;
    logic [2:0] bot;
    logic [1:0] tw;
  } bf_addr_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] a);
    return {a[0], a[1], a[2]};
  endfunction

  // step[3:2] is the stage s, step[1:0] the butterfly b within the stage.
  function automatic bf_addr_t bf_addr(input logic [3:0] step);
    bf_addr_t   r;
    logic [1:0] s;
    logic [1:0] b;
    logic [1:0] mask;
    logic [1:0] low;
    s    = step[3:2];
    b    = step[1:0];
    mask = 2'b11 >> (2'd2 - s);         // span-1
    low  = b & mask;                     // position inside the butterfly group
    r.top = ({1'b0, b >> s} << (s + 2'd1)) | {1'b0, low};
    r.bot = r.top + (3'd1 << s);
    r.tw  = low << (2'd2 - s);
    return r;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] sh;
    sh = v >>> NORM_SH;
    if (sh > SAT_HI) begin
      sh = SAT_HI;
    end else if (sh < SAT_LO) begin
      sh = SAT_LO;
    end else begin
      sh = sh;
    end
    return sh[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// ifft_butterfly: combinational radix-2 DIT butterfly for the inverse transform.
//   top_re/top_im, bot_re/bot_im : operands from the register file
//   tw                           : twiddle index t, W = e^{+j*pi*t/4}
//   sum_re/sum_im                : top + W*bot
//   dif_re/dif_im                : top - W*bot
module ifft_butterfly
  import ifft_pkg::*;
(
  input  logic signed [ACC_W-1:0] top_re,
  input  logic signed [ACC_W-1:0] top_im,
  input  logic signed [ACC_W-1:0] bot_re,
  input  logic signed [ACC_W-1:0] bot_im,
  input  logic [1:0]              tw,
  output logic signed [ACC_W-1:0] sum_re,
  output logic signed [ACC_W-1:0] sum_im,
  output logic signed [ACC_W-1:0] dif_re,
  output logic signed [ACC_W-1:0] dif_im
);

  localparam int PW = ACC_W + 10;

  logic signed [PW-1:0]    cbr;
  logic signed [PW-1:0]    cbi;
  logic signed [PW-1:0]    tr;
  logic signed [PW-1:0]    ti;
  logic signed [ACC_W-1:0] wr;
  logic signed [ACC_W-1:0] wi;

  // Twiddle multiply of the bottom operand, then sum and difference.
  always_comb begin
    cbr = PW'(bot_re) * PW'(TW_C);
    cbi = PW'(bot_im) * PW'(TW_C);
    tr  = '0;
    ti  = '0;
    wr  = bot_re;
    wi  = bot_im;
    case (tw)
      2'd0: begin
        wr = bot_re;
        wi = bot_im;
      end
      2'd1: begin
        // (1+j)/sqrt2, floor shift keeps the rounding identical to the reference rule
        tr = (cbr - cbi) >>> TW_FRAC;
        ti = (cbr + cbi) >>> TW_FRAC;
        wr = tr[ACC_W-1:0];
        wi = ti[ACC_W-1:0];
      end
      2'd2: begin
        wr = -bot_im;
        wi = bot_re;
      end
      2'd3: begin
        // (-1+j)/sqrt2
        tr = (-cbr - cbi) >>> TW_FRAC;
        ti = (cbr - cbi) >>> TW_FRAC;
        wr = tr[ACC_W-1:0];
        wi = ti[ACC_W-1:0];
      end
      default: begin
        wr = bot_re;
        wi = bot_im;
      end
    endcase
    sum_re = top_re + wr;
    sum_im = top_im + wi;
    dif_re = top_re - wr;
    dif_im = top_im - wi;
  end

endmodule

// File: rtl/ifft8_serial.sv
// ifft8_serial: serial 8-point inverse FFT, one time-multiplexed butterfly.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input bin handshake, bins X[0..7] in natural order
//   in_re/in_im          : input bin (IN_W signed per component)
//   out_valid/out_ready  : output sample handshake, samples x[0..7] in natural order
//   out_re/out_im        : output sample (OUT_W signed, saturated)
//   out_last             : marks x[7]
//   busy                 : high while computing or unloading
// Flow: LOAD (8 bins, stored bit-reversed) -> COMPUTE (12 butterflies) -> UNLOAD (8 samples).
module ifft8_serial
  import ifft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_re,
  input  logic signed [IN_W-1:0]  in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic                    out_last,
  output logic                    busy
);

  state_t                  state;
  state_t                  state_nx;
  logic [2:0]              cnt;
  logic [2:0]              cnt_inc;
  logic [3:0]              step;
  logic signed [ACC_W-1:0] rf_re [0:7];
  logic signed [ACC_W-1:0] rf_im [0:7];
  bf_addr_t                addr;
  logic                    in_fire;
  logic                    out_fire;
  logic                    last_step;
  logic signed [ACC_W-1:0] sum_re;
  logic signed [ACC_W-1:0] sum_im;
  logic signed [ACC_W-1:0] dif_re;
  logic signed [ACC_W-1:0] dif_im;

  // Handshake qualifiers and the butterfly addressing for the current step.
  always_comb begin
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
    cnt_inc   = cnt + 3'd1;
    last_step = (step == 4'(LAST_STEP));
    addr      = bf_addr(step);
  end

  ifft_butterfly u_bf (
    .top_re (rf_re[addr.top]),
    .top_im (rf_im[addr.top]),
    .bot_re (rf_re[addr.bot]),
    .bot_im (rf_im[addr.bot]),
    .tw     (addr.tw),
    .sum_re (sum_re),
    .sum_im (sum_im),
    .dif_re (dif_re),
    .dif_im (dif_im)
  );

  // Next-state logic of the LOAD/COMPUTE/UNLOAD controller.
  always_comb begin
    state_nx = state;
    case (state)
      LOAD: begin
        if (in_fire && (cnt == 3'd7)) begin
          state_nx = COMPUTE;
        end else begin
          state_nx = LOAD;
        end
      end
      COMPUTE: begin
        if (last_step) begin
          state_nx = UNLOAD;
        end else begin
          state_nx = COMPUTE;
        end
      end
      UNLOAD: begin
        if (out_fire && (cnt == 3'd7)) begin
          state_nx = LOAD;
        end else begin
          state_nx = UNLOAD;
        end
      end
      default: begin
        state_nx = LOAD;
      end
    endcase
  end

  // State, counters and the registered handshake/output signals.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= 3'd0;
      step      <= 4'd0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx == LOAD);
      busy      <= (state_nx != LOAD);
      out_valid <= (state_nx == UNLOAD);
      case (state)
        LOAD: begin
          if (in_fire) begin
            cnt <= cnt_inc;
          end
        end
        COMPUTE: begin
          if (last_step) begin
            step     <= 4'd0;
            cnt      <= 3'd0;
            // rf[0] was last written by the first butterfly of the final stage,
            // so it is already final while the last butterfly (3/7) is written.
            out_re   <= sat_out(rf_re[0]);
            out_im   <= sat_out(rf_im[0]);
            out_last <= 1'b0;
          end else begin
            step <= step + 4'd1;
          end
        end
        UNLOAD: begin
          if (out_fire) begin
            cnt <= cnt_inc;
            if (cnt == 3'd7) begin
              out_last <= 1'b0;
            end else begin
              out_re   <= sat_out(rf_re[cnt_inc]);
              out_im   <= sat_out(rf_im[cnt_inc]);
              out_last <= (cnt_inc == 3'd7);
            end
          end
        end
        default: begin
          cnt  <= 3'd0;
          step <= 4'd0;
        end
      endcase
    end
  end

  // Register file: bit-reversed bin capture, then in-place butterfly write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_re <= rf_re;
      rf_im <= rf_im;
    end else if ((state == LOAD) && in_fire) begin
      rf_re[bitrev3(cnt)] <= ACC_W'(in_re);
      rf_im[bitrev3(cnt)] <= ACC_W'(in_im);
    end else if (state == COMPUTE) begin
      rf_re[addr.top] <= sum_re;
      rf_im[addr.top] <= sum_im;
      rf_re[addr.bot] <= dif_re;
      rf_im[addr.bot] <= dif_im;
    end else begin
      rf_re <= rf_re;
      rf_im <= rf_im;
    end
  end

endmodule
